// File: rtl/regfile_dma_if.sv
// Bundle of command, stream and register-file signals for the bulk-access block.
// slave  : view of the regfile_dma block itself.
// master : view of the surrounding environment (command issuer, stream ends, rf).
interface regfile_dma_if #(
    parameter int N = 5
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_op;
    logic [N-1:0]   cmd_base;
    logic [N:0]     cmd_count;
    logic           busy;
    logic           done;
    logic           ld_valid;
    logic           ld_ready;
    logic [31:0]    ld_data;
    logic           dp_valid;
    logic           dp_ready;
    logic [31:0]    dp_data;
    logic           dp_last;
    logic [N-1:0]   rf_ra;
    logic [31:0]    rf_rd;
    logic           rf_we;
    logic [N-1:0]   rf_wa;
    logic [31:0]    rf_wd;

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_count,
        input  ld_valid, ld_data, dp_ready, rf_rd,
        output cmd_ready, busy, done, ld_ready,
        output dp_valid, dp_data, dp_last,
        output rf_ra, rf_we, rf_wa, rf_wd
    );

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_count,
        output ld_valid, ld_data, dp_ready, rf_rd,
        input  cmd_ready, busy, done, ld_ready,
        input  dp_valid, dp_data, dp_last,
        input  rf_ra, rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/regfile_dma.sv
// Bulk-access initiator for a 2**N x 32 register file.
// DUMP streams a register range out through the rf read port (zero-latency data),
// LOAD streams words into the rf write port; one word per cycle, valid/ready on
// both stream sides. Addresses wrap modulo 2**N.
module regfile_dma #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    regfile_dma_if.slave bus
);
    localparam int         DEPTH = 1 << N;
    localparam logic [N:0] FULL  = (N+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        LOAD,
        DONE
    } state_t;

    state_t       state, state_n;
    logic [N-1:0] addr, addr_n;
    logic [N:0]   remain, remain_n;
    logic [N:0]   count_clamped;
    logic         last_word;

    // Requests beyond the file depth are trimmed so every register is visited at most once.
    assign count_clamped = (bus.cmd_count > FULL) ? FULL : bus.cmd_count;
    assign last_word     = (remain == (N+1)'(1));

    // State and transfer registers; reset abandons any transfer without a done pulse.
    always_ff @(posedge clk) begin
        // NOTE: registers update with <= so every flop samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            addr   <= '0;
            remain <= '0;
        end else begin
            state  <= state_n;
            addr   <= addr_n;
            remain <= remain_n;
        end
    end

    // Next-state: accept commands in IDLE, advance one word per stream handshake.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n  = state;
        addr_n   = addr;
        remain_n = remain;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_n   = bus.cmd_base;
                    remain_n = count_clamped;
                    if (count_clamped == '0)
                        state_n = DONE;
                    else
                        state_n = bus.cmd_op ? LOAD : DUMP;
                end
            end
            DUMP: begin
                if (bus.dp_ready) begin
                    addr_n   = addr + N'(1);
                    remain_n = remain - (N+1)'(1);
                    if (last_word)
                        state_n = DONE;
                end
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    addr_n   = addr + N'(1);
                    remain_n = remain - (N+1)'(1);
                    if (last_word)
                        state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode: stream strobes only in their own state; address/data are pass-through.
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.dp_valid  = (state == DUMP);
        bus.dp_last   = (state == DUMP) && last_word;
        bus.ld_ready  = (state == LOAD);
        bus.rf_we     = (state == LOAD) && bus.ld_valid;
        bus.rf_ra     = addr;
        bus.rf_wa     = addr;
        bus.dp_data   = bus.rf_rd;
        bus.rf_wd     = bus.ld_data;
    end
endmodule

// File: tb/tb_regfile_dma.sv
// Self-checking bench for regfile_dma: a behavioural register file, a scoreboard of
// expected dump beats and rf writes, a command vector table and hand-written sequences
// for the held-ready, reset-abort and busy-command cases.
module tb_regfile_dma;
    localparam int N     = 5;
    localparam int DEPTH = 1 << N;

    typedef struct packed {
        logic [N-1:0] addr;
        logic [31:0]  data;
        logic         last;
    } dp_exp_t;

    typedef struct packed {
        logic [N-1:0] addr;
        logic [31:0]  data;
    } wr_exp_t;

    typedef struct {
        bit op;
        int base;
        int count;
        bit gap;
        int exp_words;
        int exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    regfile_dma_if #(.N(N)) bus ();

    regfile_dma #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, clocked write, address 0 discards writes.
    logic [31:0]  rf  [DEPTH];
    logic [31:0]  mdl [DEPTH];
    logic         pre_we;
    logic [N-1:0] pre_wa;
    logic [31:0]  pre_wd;

    assign bus.rf_rd = rf[bus.rf_ra];

    always @(posedge clk) begin
        if (pre_we)
            rf[pre_wa] <= pre_wd;
        else if (bus.rf_we && bus.rf_wa != '0)
            rf[bus.rf_wa] <= bus.rf_wd;
    end

    int vec_cnt = 0;
    int miscmp  = 0;

    dp_exp_t dq[$];
    wr_exp_t wq[$];

    int busy_cnt = 0;
    int done_cnt = 0;
    int we_cnt   = 0;
    int dpv_cnt  = 0;
    int acc_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scores stream handshakes and rf writes against the queues, counts events.
    always @(negedge clk) begin
        dp_exp_t e;
        wr_exp_t w;
        if (!reset) begin
            if (bus.cmd_valid && bus.cmd_ready) acc_cnt <= acc_cnt + 1;
            if (bus.busy)     busy_cnt <= busy_cnt + 1;
            if (bus.done)     done_cnt <= done_cnt + 1;
            if (bus.dp_valid) dpv_cnt  <= dpv_cnt + 1;
            if (bus.rf_we)    we_cnt   <= we_cnt + 1;
            if (!bus.dp_valid) check("dp_last_idle", bus.dp_last, 0);
            if (!bus.ld_ready) check("rf_we_idle", bus.rf_we, 0);
            if (bus.dp_valid && bus.dp_ready) begin
                check("dp_beat_expected", 32'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    check("dp_addr", 32'(bus.rf_ra), 32'(e.addr));
                    check("dp_data", bus.dp_data, e.data);
                    check("dp_last", 32'(bus.dp_last), 32'(e.last));
                end
            end
            if (bus.rf_we) begin
                check("wr_expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(bus.rf_wa), 32'(w.addr));
                    check("wr_data", bus.rf_wd, w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares", vec_cnt, miscmp);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pre(input int a, input logic [31:0] d);
        pre_we = 1'b1;
        pre_wa = N'(a);
        pre_wd = d;
        mdl[a] = (a == 0) ? 32'h0 : d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!bus.cmd_ready && c < 100) begin
            tick();
            c++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
    endtask

    task automatic offer(input bit op, input int base, input int count);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = N'(base);
        bus.cmd_count = (N+1)'(count);
    endtask

    // Issues one command with streams always ready (optional one-cycle ld gap after the
    // first word) and checks beat/write/busy/done totals against the expectation.
    task automatic run_cmd(input bit op, input int base, input int count, input bit gap,
                           input int exp_words, input int exp_busy, input int tag);
        logic [31:0] words[$];
        int n, a, i, b0, d0, w0, v0;
        bit seen, fire;
        n = (count > DEPTH) ? DEPTH : count;
        for (int k = 0; k < n; k++) begin
            a = (base + k) % DEPTH;
            if (op) begin
                words.push_back(32'(tag) * 32'h10000 + 32'(11 * (k + 1)));
                wq.push_back('{addr: N'(a), data: words[k]});
                mdl[a] = (a == 0) ? 32'h0 : words[k];
            end else begin
                dq.push_back('{addr: N'(a), data: mdl[a], last: (k == n - 1)});
            end
        end
        wait_ready();
        b0 = busy_cnt; d0 = done_cnt; w0 = we_cnt; v0 = dpv_cnt;
        offer(op, base, count);
        bus.dp_ready = 1'b1;
        bus.ld_valid = op && (n > 0);
        if (op && n > 0) bus.ld_data = words[0];
        tick();
        bus.cmd_valid = 1'b0;
        i = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            fire = bus.ld_valid && bus.ld_ready;
            seen = bus.done;
            tick();
            if (op) begin
                if (fire) begin
                    i++;
                    if (i < n) bus.ld_data = words[i];
                    bus.ld_valid = (i < n) && !(gap && i == 1);
                end else if (i < n && !bus.ld_valid) begin
                    bus.ld_valid = 1'b1;
                end
            end
        end
        bus.ld_valid = 1'b0;
        check("done_seen", 32'(seen), 1);
        check("done_pulses", 32'(done_cnt - d0), 1);
        check("busy_cycles", 32'(busy_cnt - b0), 32'(exp_busy));
        check("rf_we_count", 32'(we_cnt - w0), op ? 32'(exp_words) : 0);
        check("dp_valid_count", 32'(dpv_cnt - v0), op ? 0 : 32'(exp_words));
        check("queues_drained", 32'(dq.size() + wq.size()), 0);
    endtask

    localparam logic [31:0] VA = 32'hAAAA_0030;
    localparam logic [31:0] VB = 32'hBBBB_0031;
    localparam logic [31:0] VC = 32'hCCCC_0001;

    logic [31:0]  t1_d [5] = '{VA, VA, VB, 32'h0, VC};
    int           t1_a [5] = '{30, 30, 31, 0, 1};
    logic         t1_l [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         t1_r [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    vec_t vt [10];

    initial begin
        int d0, w0, a0, v0, nacc;
        bit fire, seen;
        int li;
        logic [31:0] lw [2];

        vt[0] = '{1'b1,  2,  3, 1'b1,  3,  5};
        vt[1] = '{1'b0,  2,  3, 1'b0,  3,  4};
        vt[2] = '{1'b0,  4,  0, 1'b0,  0,  1};
        vt[3] = '{1'b1,  9,  0, 1'b0,  0,  1};
        vt[4] = '{1'b0,  7, 32, 1'b0, 32, 33};
        vt[5] = '{1'b0,  7, 40, 1'b0, 32, 33};
        vt[6] = '{1'b1, 30,  3, 1'b0,  3,  4};
        vt[7] = '{1'b0, 29,  4, 1'b0,  4,  5};
        vt[8] = '{1'b0,  0, 63, 1'b0, 32, 33};
        vt[9] = '{1'b1,  0,  1, 1'b0,  1,  2};

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_count = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.dp_ready  = 1'b0;
        pre_we        = 1'b0;
        pre_wa        = '0;
        pre_wd        = '0;

        for (int k = 0; k < DEPTH; k++) pre(k, (k == 0) ? 32'h0 : 32'h5000_0000 + 32'(k));
        tick();

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_done",      32'(bus.done), 0);
        check("rst_dp_valid",  32'(bus.dp_valid), 0);
        check("rst_dp_last",   32'(bus.dp_last), 0);
        check("rst_ld_ready",  32'(bus.ld_ready), 0);
        check("rst_rf_we",     32'(bus.rf_we), 0);
        check("rst_rf_ra",     32'(bus.rf_ra), 0);
        check("rst_rf_wa",     32'(bus.rf_wa), 0);
        reset = 1'b0;
        tick();

        // Wrapping dump with one held beat
        pre(30, VA); pre(31, VB); pre(1, VC); pre(0, 32'h0);
        wait_ready();
        d0 = done_cnt;
        dq.push_back('{addr: N'(30), data: VA,    last: 1'b0});
        dq.push_back('{addr: N'(31), data: VB,    last: 1'b0});
        dq.push_back('{addr: N'(0),  data: 32'h0, last: 1'b0});
        dq.push_back('{addr: N'(1),  data: VC,    last: 1'b1});
        offer(1'b0, 30, 4);
        bus.dp_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.dp_ready = t1_r[k];
            @(negedge clk);
            check("t1_dp_valid", 32'(bus.dp_valid), 1);
            check("t1_dp_data",  bus.dp_data, t1_d[k]);
            check("t1_rf_ra",    32'(bus.rf_ra), 32'(t1_a[k]));
            check("t1_dp_last",  32'(bus.dp_last), 32'(t1_l[k]));
            tick();
        end
        @(negedge clk);
        check("t1_done",       32'(bus.done), 1);
        check("t1_done_dpv",   32'(bus.dp_valid), 0);
        tick();
        @(negedge clk);
        check("t1_done_once",  32'(bus.done), 0);
        check("t1_ready_back", 32'(bus.cmd_ready), 1);
        check("t1_done_count", 32'(done_cnt - d0), 1);
        tick();

        // Command vector table
        for (int v = 0; v < 10; v++)
            run_cmd(vt[v].op, vt[v].base, vt[v].count, vt[v].gap,
                    vt[v].exp_words, vt[v].exp_busy, v);

        // Reset in the middle of a load
        wait_ready();
        d0 = done_cnt; w0 = we_cnt;
        lw[0] = 32'hDEAD_0012;
        lw[1] = 32'hDEAD_0013;
        wq.push_back('{addr: N'(12), data: lw[0]});
        wq.push_back('{addr: N'(13), data: lw[1]});
        mdl[12] = lw[0];
        mdl[13] = lw[1];
        offer(1'b1, 12, 5);
        bus.ld_valid = 1'b1;
        bus.ld_data  = lw[0];
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t5_ld_ready", 32'(bus.ld_ready), 1);
            tick();
            bus.ld_data = lw[1];
        end
        reset        = 1'b1;
        bus.ld_valid = 1'b0;
        tick();
        check("t5_cmd_ready", 32'(bus.cmd_ready), 1);
        check("t5_busy",      32'(bus.busy), 0);
        check("t5_done",      32'(bus.done), 0);
        check("t5_ld_ready",  32'(bus.ld_ready), 0);
        check("t5_rf_wa",     32'(bus.rf_wa), 0);
        reset = 1'b0;
        tick(); tick(); tick();
        check("t5_no_done",   32'(done_cnt - d0), 0);
        check("t5_two_writes", 32'(we_cnt - w0), 2);
        run_cmd(1'b0, 12, 5, 1'b0, 5, 6, 0);

        // Command held valid while busy is not taken until IDLE
        wait_ready();
        a0 = acc_cnt; v0 = dpv_cnt;
        lw[0] = 32'hFEED_0008;
        lw[1] = 32'hFEED_0009;
        wq.push_back('{addr: N'(8), data: lw[0]});
        wq.push_back('{addr: N'(9), data: lw[1]});
        mdl[8] = lw[0];
        mdl[9] = lw[1];
        for (int k = 0; k < 3; k++)
            dq.push_back('{addr: N'(20 + k), data: mdl[20 + k], last: (k == 2)});
        offer(1'b1, 8, 2);
        bus.ld_valid = 1'b1;
        bus.ld_data  = lw[0];
        bus.dp_ready = 1'b1;
        tick();
        offer(1'b0, 20, 3);
        li = 0;
        nacc = 0;
        for (int c = 0; c < 50 && nacc == 0; c++) begin
            @(negedge clk);
            fire = bus.ld_valid && bus.ld_ready;
            if (bus.busy) check("t6_ready_while_busy", 32'(bus.cmd_ready), 0);
            if (bus.cmd_valid && bus.cmd_ready) nacc++;
            tick();
            if (fire) begin
                li++;
                if (li < 2) bus.ld_data = lw[li];
                else bus.ld_valid = 1'b0;
            end
        end
        bus.cmd_valid = 1'b0;
        check("t6_second_accept", 32'(nacc), 1);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = bus.done;
            tick();
        end
        check("t6_done_seen", 32'(seen), 1);
        tick();
        check("t6_accepts", 32'(acc_cnt - a0), 2);
        check("t6_dump_beats", 32'(dpv_cnt - v0), 3);
        check("t6_queues", 32'(dq.size() + wq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end
endmodule
